// File: rtl/loader_pkg.sv
// Shared types for the boot loader: FSM state encoding and error codes.
package loader_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DONE, ERR} loader_state_t;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up counter that sticks at all-ones; clear beats enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         count <= '0;
    else if (clr)                      count <= '0;
    else if (en && (count != {W{1'b1}})) count <= count + 1'b1;
  end
endmodule

// File: rtl/prog_loader.sv
// Boot sequencer: streams a program into instruction memory, then runs the core
// and counts cycles until done. Optional watchdog: define LOADER_TIMEOUT_EN.
module prog_loader
  import loader_pkg::*;
#(
  parameter int          PC_W    = 6,
  parameter int          INSTR_W = 9,
  parameter int          CNT_W   = 16,
  parameter int unsigned TIMEOUT = 4000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic               im_wen,
  output logic [PC_W-1:0]    im_waddr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic               core_reset,
  input  logic               core_done,
  output logic               busy,
  output logic               finished,
  output logic               error,
  output logic [1:0]         err_code,
  output logic [PC_W:0]      prog_len,
  output logic [CNT_W-1:0]   cycle_count
);
`ifdef LOADER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  loader_state_t   state, nxt;
  logic [PC_W-1:0] addr;
  logic            clr, accept, ovf, tmo, tmo_hit, cnt_en;

  assign tmo     = TMO_EN && (cycle_count == CNT_W'(TIMEOUT));
  assign tmo_hit = (state == RUN) && !core_done && tmo;
  assign cnt_en  = (state == RUN) && !core_done && !tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt      = state;
    clr      = 1'b0;
    accept   = 1'b0;
    ovf      = 1'b0;
    in_ready = 1'b0;
    case (state)
      IDLE, DONE, ERR: if (start) begin
        nxt = LOAD;
        clr = 1'b1;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (in_last) nxt = RUN;
          else if (addr == {PC_W{1'b1}}) begin
            nxt = ERR;
            ovf = 1'b1;
          end
        end
      end
      RUN: begin
        if (core_done)    nxt = DONE;
        else if (tmo_hit) nxt = ERR;
      end
      default: nxt = IDLE;
    endcase
  end

  // The top-address word is still written before the overflow error is taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr     <= '0;
      prog_len <= '0;
      err_code <= ERR_NONE;
    end else begin
      if (clr) begin
        addr     <= '0;
        prog_len <= '0;
      end else if (accept) begin
        addr     <= addr + 1'b1;
        prog_len <= prog_len + 1'b1;
      end
      if (clr)          err_code <= ERR_NONE;
      else if (ovf)     err_code <= ERR_OVERFLOW;
      else if (tmo_hit) err_code <= ERR_TIMEOUT;
    end
  end

  sat_counter #(.W(CNT_W)) u_cyc (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .en    (cnt_en),
    .count (cycle_count)
  );

  assign im_wen     = accept;
  assign im_waddr   = accept ? addr : '0;
  assign im_wdata   = accept ? in_data : '0;
  assign core_reset = (state != RUN);
  assign busy       = (state == LOAD) || (state == RUN);
  assign finished   = (state == DONE);
  assign error      = (state == ERR);
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: load/run, gaps, overflow, watchdog, async reset, reload.
module tb_prog_loader;
  logic       clk = 1'b0;
  logic       reset, start, in_valid, in_last, core_done;
  logic [8:0] in_data;
  logic       in_ready, im_wen, core_reset, busy, finished, error;
  logic [5:0] im_waddr;
  logic [8:0] im_wdata;
  logic [1:0] err_code;
  logic [6:0] prog_len;
  logic [15:0] cycle_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [5:0] wa[$];
  logic [8:0] wd[$];

  always #5 clk = ~clk;

  prog_loader #(.PC_W(6), .INSTR_W(9), .CNT_W(16), .TIMEOUT(20)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .im_wen(im_wen), .im_waddr(im_waddr), .im_wdata(im_wdata),
    .core_reset(core_reset), .core_done(core_done), .busy(busy),
    .finished(finished), .error(error), .err_code(err_code),
    .prog_len(prog_len), .cycle_count(cycle_count)
  );

  // Record every memory write mid-cycle, where the combinational write port is settled.
  always @(negedge clk) if (im_wen === 1'b1) begin
    wa.push_back(im_waddr);
    wd.push_back(im_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [8:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 9'h000; core_done = 1'b0;
    repeat (2) step();
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_in_ready",   32'(in_ready),   32'd0);
    chk("rst_im_wen",     32'(im_wen),     32'd0);
    chk("rst_im_waddr",   32'(im_waddr),   32'd0);
    chk("rst_im_wdata",   32'(im_wdata),   32'd0);
    chk("rst_flags",      32'({busy, finished, error}), 32'd0);
    chk("rst_err_code",   32'(err_code),   32'd0);
    chk("rst_prog_len",   32'(prog_len),   32'd0);
    chk("rst_cycles",     32'(cycle_count), 32'd0);
    reset = 1'b0;
    step();

    // Basic load of 3 words, core done after 7 run cycles
    core_done = 1'b1;             // ignored in IDLE
    step();
    chk("idle_ignores_done", 32'({busy, finished}), 32'd0);
    core_done = 1'b0;
    pulse_start();
    chk("start_in_ready", 32'(in_ready), 32'd1);
    chk("load_busy",      32'(busy),     32'd1);
    wa.delete(); wd.delete();
    send(9'h1A0, 1'b0);
    send(9'h0F3, 1'b0);
    chk("mid_load_core_reset", 32'(core_reset), 32'd1);
    send(9'h100, 1'b1);
    chk("run_core_reset", 32'(core_reset), 32'd0);
    chk("run_in_ready",   32'(in_ready),   32'd0);
    chk("b_nwrites", 32'(wa.size()), 32'd3);
    if (wa.size() == 3) begin
      chk("b_a0", 32'(wa[0]), 32'd0); chk("b_d0", 32'(wd[0]), 32'h1A0);
      chk("b_a1", 32'(wa[1]), 32'd1); chk("b_d1", 32'(wd[1]), 32'h0F3);
      chk("b_a2", 32'(wa[2]), 32'd2); chk("b_d2", 32'(wd[2]), 32'h100);
    end
    chk("b_prog_len", 32'(prog_len), 32'd3);
    repeat (7) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("b_finished", 32'(finished),    32'd1);
    chk("b_cycles",   32'(cycle_count), 32'd7);
    chk("b_done_core_reset", 32'(core_reset), 32'd1);
    chk("b_done_busy", 32'(busy), 32'd0);
    step();
    chk("b_done_hold", 32'({prog_len, cycle_count}), {9'd0, 7'd3, 16'd7});

    // Reload from DONE; core_done during DONE and LOAD has no effect
    core_done = 1'b1;
    step();
    chk("done_ignores_done", 32'(finished), 32'd1);
    pulse_start();
    chk("reload_cleared", 32'({prog_len, cycle_count}), 32'd0);
    step();
    chk("load_ignores_done", 32'({busy, core_reset, finished}), 32'b110);
    core_done = 1'b0;
    wa.delete(); wd.delete();
    send(9'h055, 1'b1);
    chk("reload_run", 32'({busy, core_reset}), 32'b10);
    chk("reload_addr0", 32'(wa.size() == 1 && wa[0] == 6'd0), 32'd1);
    chk("reload_len", 32'(prog_len), 32'd1);
    repeat (3) step();
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("reload_done", 32'({finished, cycle_count}), {15'd0, 1'b1, 16'd3});

    // Four words with 2-cycle valid gaps
    pulse_start();
    wa.delete(); wd.delete();
    for (int i = 0; i < 4; i++) begin
      send(9'(9'h010 + i), i == 3);
      if (i < 3) begin
        chk("gap_core_reset", 32'(core_reset), 32'd1);
        in_data = 9'h1FF;
        step();
        chk("gap_wdata_zero", 32'({im_wen, im_wdata}), 32'd0);
        step();
      end
    end
    chk("gap_run", 32'(core_reset), 32'd0);
    chk("gap_nwrites", 32'(wa.size()), 32'd4);
    for (int i = 0; i < 4 && i < wa.size(); i++)
      chk("gap_addr", 32'(wa[i]), 32'(i));
    chk("gap_len", 32'(prog_len), 32'd4);
    core_done = 1'b1;
    step();
    core_done = 1'b0;

    // 64 words without in_last -> overflow
    pulse_start();
    wa.delete(); wd.delete();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) chk("ovf_pre_busy", 32'(busy), 32'd1);
      send(9'(i * 3), 1'b0);
    end
    chk("ovf_error",    32'(error),    32'd1);
    chk("ovf_code",     32'(err_code), 32'd1);
    chk("ovf_len",      32'(prog_len), 32'd64);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_core_reset", 32'(core_reset), 32'd1);
    chk("ovf_nwrites",  32'(wa.size()), 32'd64);
    if (wa.size() == 64)
      chk("ovf_last_write", 32'({wa[63], wd[63]}), 32'({6'd63, 9'(63 * 3)}));
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("err_ignores_done", 32'({error, finished}), 32'b10);

    // Watchdog (TIMEOUT=20) or free-running counter without it
    pulse_start();
    chk("err_reload_code", 32'(err_code), 32'd0);
    send(9'h0AA, 1'b1);
`ifdef LOADER_TIMEOUT_EN
    repeat (20) step();
    chk("tmo_pre", 32'({busy, cycle_count}), {15'd0, 1'b1, 16'd20});
    step();
    chk("tmo_error",  32'(error),       32'd1);
    chk("tmo_code",   32'(err_code),    32'd2);
    chk("tmo_cycles", 32'(cycle_count), 32'd20);
    step();
    chk("tmo_hold",   32'(cycle_count), 32'd20);
`else
    repeat (40) step();
    chk("notmo_busy",   32'({busy, error}), 32'b10);
    chk("notmo_cycles", 32'(cycle_count),   32'd40);
    chk("notmo_code",   32'(err_code),      32'd0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
`endif

    // Async reset after 2 of 5 words
    pulse_start();
    send(9'h101, 1'b0);
    send(9'h102, 1'b0);
    in_valid = 1'b1; in_data = 9'h103;
    #1 reset = 1'b1;
    #1;
    chk("arst_core_reset", 32'(core_reset), 32'd1);
    chk("arst_idle", 32'({busy, finished, error, in_ready, im_wen}), 32'd0);
    chk("arst_len", 32'(prog_len), 32'd0);
    in_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    pulse_start();
    wa.delete(); wd.delete();
    send(9'h1EE, 1'b0);
    chk("arst_reload_addr0", 32'(wa.size() == 1 && wa[0] == 6'd0 && wd[0] == 9'h1EE), 32'd1);
    chk("arst_reload_len", 32'(prog_len), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
